// File: rtl/dffram_1r1w.sv
// Simple-dual-port DFFRAM model: one write port with byte enables, one registered read port,
// selectable read-during-write behaviour and an optional post-reset array clear.
module dffram_1r1w #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 256,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = $clog2(DEPTH),
  localparam int NB            = WIDTH / 8
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             READY,
  input  logic [NB-1:0]    WEN,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] Di,
  input  logic             REN,
  input  logic [AW-1:0]    RA,
  output logic [WIDTH-1:0] Do,
  output logic             RVALID
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [AW-1:0]     clr_cnt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rd_word_p0;

  function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_word,
                                                   input logic [WIDTH-1:0] new_word,
                                                   input logic [NB-1:0]    lane_en);
    logic [WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (lane_en[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_cnt == AW'(DEPTH - 1)) state_nxt = RUN;
  end

  // READY is registered so it stays low on the reset edge even when no clear is needed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt <= '0;
      READY   <= 1'b0;
    end else begin
      state <= state_nxt;
      READY <= (state_nxt == RUN);
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (READY) begin
        for (int i = 0; i < NB; i++) begin
          if (WEN[i]) mem[WA][8*i +: 8] <= Di[8*i +: 8];
        end
      end
    end
  end

  // Stage p0 -> output register: collision lanes take the incoming data when write-first.
  always_comb begin
    rd_word_p0 = mem[RA];
    if (BYPASS != 0 && WA == RA) rd_word_p0 = merge_lanes(mem[RA], Di, WEN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      Do     <= '0;
      RVALID <= 1'b0;
    end else if (READY && REN) begin
      Do     <= rd_word_p0;
      RVALID <= 1'b1;
    end else begin
      Do     <= '0;
      RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dffram_1r1w.sv
// Directed bench for dffram_1r1w: four instances (write-first, read-first, wide/deep,
// no-clear) share the data-side inputs and have private resets.
module tb_dffram_1r1w;

  logic        clk = 1'b0;
  logic        rst_ab, rst_c, rst_d;
  logic [7:0]  wen;
  logic [8:0]  wa, ra;
  logic [63:0] di;
  logic        ren;

  logic        ready_a, ready_b, ready_c, ready_d;
  logic        rvalid_a, rvalid_b, rvalid_c, rvalid_d;
  logic [31:0] do_a, do_b, do_d;
  logic [63:0] do_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dffram_1r1w #(.WIDTH(32), .DEPTH(16), .BYPASS(1), .CLEAR_ON_RESET(1)) dut_a (
    .CLK(clk), .RST(rst_ab), .READY(ready_a), .WEN(wen[3:0]), .WA(wa[3:0]), .Di(di[31:0]),
    .REN(ren), .RA(ra[3:0]), .Do(do_a), .RVALID(rvalid_a));

  dffram_1r1w #(.WIDTH(32), .DEPTH(16), .BYPASS(0), .CLEAR_ON_RESET(1)) dut_b (
    .CLK(clk), .RST(rst_ab), .READY(ready_b), .WEN(wen[3:0]), .WA(wa[3:0]), .Di(di[31:0]),
    .REN(ren), .RA(ra[3:0]), .Do(do_b), .RVALID(rvalid_b));

  dffram_1r1w #(.WIDTH(64), .DEPTH(512), .BYPASS(1), .CLEAR_ON_RESET(1)) dut_c (
    .CLK(clk), .RST(rst_c), .READY(ready_c), .WEN(wen), .WA(wa), .Di(di),
    .REN(ren), .RA(ra), .Do(do_c), .RVALID(rvalid_c));

  dffram_1r1w #(.WIDTH(32), .DEPTH(16), .BYPASS(1), .CLEAR_ON_RESET(0)) dut_d (
    .CLK(clk), .RST(rst_d), .READY(ready_d), .WEN(wen[3:0]), .WA(wa[3:0]), .Di(di[31:0]),
    .REN(ren), .RA(ra[3:0]), .Do(do_d), .RVALID(rvalid_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [8:0] addr, input logic [63:0] data, input logic [7:0] we);
    wen = we; wa = addr; di = data;
    tick();
    wen = '0;
  endtask

  task automatic rd(input logic [8:0] addr);
    ren = 1'b1; ra = addr;
    tick();
    ren = 1'b0;
  endtask

  initial begin
    rst_ab = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    wen = '0; wa = '0; ra = '0; di = '0; ren = 1'b0;
    ticks(2);
    chk("rst_ready_a", 64'(ready_a), 64'd0);
    chk("rst_do_a", 64'(do_a), 64'd0);
    chk("rst_rvalid_a", 64'(rvalid_a), 64'd0);

    // Initial clear of the 16-word instances.
    rst_ab = 1'b0;
    ticks(15);
    chk("clr0_ready_15", 64'(ready_a), 64'd0);
    tick();
    chk("clr0_ready_16", 64'(ready_a), 64'd1);
    chk("clr0_ready_16_b", 64'(ready_b), 64'd1);

    // Preload then reset: the clear must wipe the word.
    wr(9'd5, 64'hDEADBEEF, 8'hF);
    rd(9'd5);
    chk("preload_rd5", 64'(do_a), 64'hDEADBEEF);
    rst_ab = 1'b1; tick(); rst_ab = 1'b0;
    chk("rst_pulse_ready", 64'(ready_a), 64'd0);
    chk("rst_pulse_do", 64'(do_a), 64'd0);
    ticks(15);
    chk("clr1_ready_15", 64'(ready_a), 64'd0);
    tick();
    chk("clr1_ready_16", 64'(ready_a), 64'd1);
    rd(9'd5);
    chk("clr1_rd5", 64'(do_a), 64'd0);
    chk("clr1_rvalid", 64'(rvalid_a), 64'd1);

    // Byte lanes.
    wr(9'd3, 64'h11223344, 8'hF);
    wr(9'd3, 64'hAABBCCDD, 8'b0101);
    rd(9'd3);
    chk("lanes_a", 64'(do_a), 64'h11BB33DD);
    chk("lanes_b", 64'(do_b), 64'h11BB33DD);

    // Read-during-write collision on a cleared word.
    wen = 8'b0011; wa = 9'd7; di = 64'hCAFEF00D; ren = 1'b1; ra = 9'd7;
    tick();
    wen = '0; ren = 1'b0;
    chk("coll_bypass", 64'(do_a), 64'h0000F00D);
    chk("coll_readfirst", 64'(do_b), 64'h00000000);
    rd(9'd7);
    chk("coll_after_a", 64'(do_a), 64'h0000F00D);
    chk("coll_after_b", 64'(do_b), 64'h0000F00D);

    // Concurrent ports: steady read of address 2 while writing elsewhere.
    wr(9'd2, 64'h5A5A5A5A, 8'hF);
    for (int k = 0; k < 8; k++) begin
      wen = 8'hF; wa = 9'(8 + k); di = 64'(32'h100 + k); ren = 1'b1; ra = 9'd2;
      tick();
      chk($sformatf("conc_do_%0d", k), 64'(do_a), 64'h5A5A5A5A);
      chk($sformatf("conc_rv_%0d", k), 64'(rvalid_a), 64'd1);
    end
    wen = '0;
    for (int k = 0; k < 8; k++) begin
      ra = 9'(8 + k);
      tick();
      chk($sformatf("conc_back_%0d", k), 64'(do_b), 64'(32'h100 + k));
    end

    // REN low after a valid read.
    ren = 1'b0;
    tick();
    chk("renlow_do", 64'(do_a), 64'd0);
    chk("renlow_rvalid", 64'(rvalid_a), 64'd0);

    // Reset mid-clear at clear edge 9.
    rst_ab = 1'b1; tick(); rst_ab = 1'b0;
    ticks(8);
    rst_ab = 1'b1; tick(); rst_ab = 1'b0;
    chk("mid_ready_0", 64'(ready_a), 64'd0);
    ticks(15);
    chk("mid_ready_15", 64'(ready_a), 64'd0);
    tick();
    chk("mid_ready_16", 64'(ready_a), 64'd1);
    for (int k = 0; k < 16; k++) begin
      rd(9'(k));
      chk($sformatf("mid_zero_a_%0d", k), 64'(do_a), 64'd0);
      chk($sformatf("mid_zero_b_%0d", k), 64'(do_b), 64'd0);
    end

    // No-clear instance.
    chk("d_rst_ready", 64'(ready_d), 64'd0);
    chk("d_rst_rvalid", 64'(rvalid_d), 64'd0);
    rst_d = 1'b0;
    tick();
    chk("d_ready_1", 64'(ready_d), 64'd1);
    wr(9'd3, 64'h11223344, 8'hF);
    wr(9'd3, 64'hAABBCCDD, 8'b0101);
    rd(9'd3);
    chk("d_lanes", 64'(do_d), 64'h11BB33DD);
    wr(9'd7, 64'h0, 8'hF);
    wen = 8'b0011; wa = 9'd7; di = 64'hCAFEF00D; ren = 1'b1; ra = 9'd7;
    tick();
    wen = '0; ren = 1'b0;
    chk("d_coll", 64'(do_d), 64'h0000F00D);
    rd(9'd7);
    chk("d_coll_after", 64'(do_d), 64'h0000F00D);

    // Wide/deep instance.
    chk("c_rst_ready", 64'(ready_c), 64'd0);
    rst_c = 1'b0;
    ticks(511);
    chk("c_ready_511", 64'(ready_c), 64'd0);
    tick();
    chk("c_ready_512", 64'(ready_c), 64'd1);
    wr(9'd300, 64'h1122334455667788, 8'hFF);
    wr(9'd300, 64'hAABBCCDDEEFF0011, 8'b01010101);
    rd(9'd300);
    chk("c_lanes", do_c, 64'h11BB33DD55FF7711);
    wen = 8'b0000_0011; wa = 9'd400; di = 64'h00000000CAFEF00D; ren = 1'b1; ra = 9'd400;
    tick();
    wen = '0; ren = 1'b0;
    chk("c_coll", do_c, 64'h000000000000F00D);
    rd(9'd400);
    chk("c_coll_after", do_c, 64'h000000000000F00D);
    chk("c_rvalid", 64'(rvalid_c), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
